smg_display_arbiter: RTL and testbench
======================================

SMG_DISPLAY_ARBITER -- requirements
Module: smg_display_arbiter

Interface
REQ-001 Parameter HOLD_CYC, default 25000000, minimum clock cycles a granted value stays on the display; legal range 2..2^25-1.
REQ-002 CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 RSTn  input  1  reset; asynchronous assertion, active-low.
REQ-004 A_Req  input  1  requester A wants the display; level-sensitive.
REQ-005 A_Data  input  8  requester A value as two BCD digits: [7:4] tens, [3:0] ones.
REQ-006 A_Ack  output  1  one-cycle pulse: A_Data has been latched for display.
REQ-007 B_Req  input  1  requester B wants the display; level-sensitive.
REQ-008 B_Data  input  8  requester B value, same format as A_Data.
REQ-009 B_Ack  output  1  one-cycle pulse: B_Data has been latched for display.
REQ-010 Blank_Zero  input  1  1 = suppress a leading zero in the tens digit.
REQ-011 Ten_SMG_Data  output  8  tens-digit segment code for the two-digit scan block.
REQ-012 One_SMG_Data  output  8  ones-digit segment code for the two-digit scan block.
REQ-013 Owner  output  2  current grant: 00 none, 01 A, 10 B; 11 never driven.

Function
REQ-014 Segment code SHALL be active-low, bit7 = dp (always 1), bits[6:0] = g..a.
REQ-015 Encoding SHALL be: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 (hex); BCD 10..15 = BF (dash); blank = FF.
REQ-016 The FSM SHALL have states IDLE, GRANT_A and GRANT_B; Owner SHALL be 00, 01 and 10 respectively.
REQ-017 In IDLE, a high request sampled at edge n SHALL cause, at edge n, entry to the grant state, data latch, segment output update and a single-cycle Ack for that requester.
REQ-018 If both requests are high in IDLE, grant SHALL go to the requester not served last; the last-served pointer SHALL reset to B, so A wins the first tie.
REQ-019 On every grant, a 25-bit hold counter SHALL load HOLD_CYC-1 and decrement once per cycle while in a grant state.
REQ-020 While the counter is non-zero, the grant, latched value and segment outputs SHALL be frozen; request deassertion and data changes SHALL be ignored.
REQ-021 When the counter is 0 and the other requester is high, grant SHALL pass to it on that edge, with latch, Ack and counter reload.
REQ-022 When the counter is 0, the other requester is low and the owner is still high, the owner's data SHALL be re-latched, its Ack pulsed and the counter reloaded.
REQ-023 When the counter is 0 and neither request is high, the FSM SHALL return to IDLE; segment outputs SHALL keep the last value.
REQ-024 Blank_Zero SHALL be sampled at latch time; if it is 1 and tens = 0, Ten_SMG_Data SHALL be FF; the ones digit is never blanked.
REQ-025 A_Ack and B_Ack SHALL never be high in the same cycle; each Ack SHALL be exactly one cycle wide.
REQ-026 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-027 RSTn low SHALL immediately force: state IDLE, Owner 00, A_Ack 0, B_Ack 0, Ten_SMG_Data FF, One_SMG_Data FF, hold counter 0, last-served = B.
REQ-028 Reset asserted mid-hold SHALL abort the grant with no Ack; after release, arbitration SHALL restart from IDLE under the REQ-018 tie rule.
REQ-029 The first grant after reset release SHALL occur no earlier than the first rising edge with RSTn high.

Verification (HOLD_CYC=4)
REQ-030 Reset, A_Req=1, A_Data=8'h42, Blank_Zero=0 -> next edge: Owner=01, A_Ack 1 cycle, Ten=99, One=A4.
REQ-031 Both requests high from IDLE, A_Data=8'h05, B_Data=8'h17, Blank_Zero=1 -> A first: Ten=FF, One=92; 4 cycles later B: Ten=F9, One=F8; then alternates every 4 cycles.
REQ-032 A_Req=1 for 1 cycle only -> A latched; Owner=01 for 4 cycles, then 00; outputs keep A's code.
REQ-033 A holding the grant, A_Data changes to 8'h99 at hold cycle 2 -> no output change until the reload edge, then Ten=90, One=90 with A_Ack.
REQ-034 B_Data=8'hA3 -> Ten=BF, One=B0; RSTn pulsed low mid-hold -> outputs FF and Owner 00 immediately, with no Ack.

Source files
------------

// File: rtl/smg_display_arbiter.sv
// Two-requester arbiter for a two-digit seven-segment display. A granted BCD value is latched,
// encoded to active-low segment codes and held for at least HOLD_CYC cycles.
module smg_display_arbiter #(
  parameter int unsigned HOLD_CYC = 25000000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       A_Req,
  input  logic [7:0] A_Data,
  output logic       A_Ack,
  input  logic       B_Req,
  input  logic [7:0] B_Data,
  output logic       B_Ack,
  input  logic       Blank_Zero,
  output logic [7:0] Ten_SMG_Data,
  output logic [7:0] One_SMG_Data,
  output logic [1:0] Owner
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGrantA = 2'b01,
    StGrantB = 2'b10
  } state_e;

  localparam logic [24:0] HoldLoad = 25'(HOLD_CYC - 1);

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  state_e      state_q, state_d;
  logic [24:0] cnt_q, cnt_d;
  logic        last_b_q, last_b_d;
  logic [7:0]  ten_q, ten_d;
  logic [7:0]  one_q, one_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        grant_a, grant_b;
  logic [7:0]  lat_data;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    ten_d    = ten_q;
    one_d    = one_q;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    lat_data = A_Data;

    unique case (state_q)
      StIdle: begin
        // On a tie the requester that was not served last wins.
        if (A_Req && B_Req) begin
          grant_a = last_b_q;
          grant_b = !last_b_q;
        end else begin
          grant_a = A_Req;
          grant_b = B_Req;
        end
      end
      StGrantA: begin
        if (cnt_q != 25'd0) begin
          cnt_d = cnt_q - 25'd1;
        end else if (B_Req) begin
          grant_b = 1'b1;
        end else if (A_Req) begin
          grant_a = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StGrantB: begin
        if (cnt_q != 25'd0) begin
          cnt_d = cnt_q - 25'd1;
        end else if (A_Req) begin
          grant_a = 1'b1;
        end else if (B_Req) begin
          grant_b = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (grant_b) begin
      lat_data = B_Data;
      state_d  = StGrantB;
      last_b_d = 1'b1;
      b_ack_d  = 1'b1;
    end else if (grant_a) begin
      state_d  = StGrantA;
      last_b_d = 1'b0;
      a_ack_d  = 1'b1;
    end

    if (grant_a || grant_b) begin
      cnt_d = HoldLoad;
      ten_d = (Blank_Zero && lat_data[7:4] == 4'd0) ? 8'hFF : seg_of(lat_data[7:4]);
      one_d = seg_of(lat_data[3:0]);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= StIdle;
      cnt_q    <= 25'd0;
      last_b_q <= 1'b1;
      ten_q    <= 8'hFF;
      one_q    <= 8'hFF;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      ten_q    <= ten_d;
      one_q    <= one_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
    end
  end

  assign Owner        = state_q;
  assign A_Ack        = a_ack_q;
  assign B_Ack        = b_ack_q;
  assign Ten_SMG_Data = ten_q;
  assign One_SMG_Data = one_q;

endmodule

// File: tb/tb_smg_display_arbiter.sv
// Bench for smg_display_arbiter: directed scenarios plus random traffic against a
// behavioural model of the arbitration and display rules (HOLD_CYC = 4).
module tb_smg_display_arbiter;

  localparam int Hold = 4;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b1;
  logic       A_Req = 1'b0;
  logic [7:0] A_Data = 8'h00;
  logic       B_Req = 1'b0;
  logic [7:0] B_Data = 8'h00;
  logic       Blank_Zero = 1'b0;
  logic       A_Ack, B_Ack;
  logic [7:0] Ten_SMG_Data, One_SMG_Data;
  logic [1:0] Owner;

  int total = 0;
  int bad = 0;

  smg_display_arbiter #(.HOLD_CYC(Hold)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .A_Req        (A_Req),
    .A_Data       (A_Data),
    .A_Ack        (A_Ack),
    .B_Req        (B_Req),
    .B_Data       (B_Data),
    .B_Ack        (B_Ack),
    .Blank_Zero   (Blank_Zero),
    .Ten_SMG_Data (Ten_SMG_Data),
    .One_SMG_Data (One_SMG_Data),
    .Owner        (Owner)
  );

  always #5 CLK = ~CLK;

  // Model state: owner 0 none / 1 A / 2 B, cycles left before the next arbitration point.
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
  int         m_owner, m_left;
  bit         m_last_a;
  logic [7:0] m_ten, m_one;
  logic       m_ack_a, m_ack_b;

  task automatic model_reset();
    m_owner = 0; m_left = 0; m_last_a = 0;
    m_ten = 8'hFF; m_one = 8'hFF; m_ack_a = 0; m_ack_b = 0;
  endtask

  task automatic model_edge();
    int pick;
    logic [7:0] d;
    m_ack_a = 0;
    m_ack_b = 0;
    if (m_owner != 0 && m_left > 0) begin
      m_left = m_left - 1;
      return;
    end
    if (m_owner == 1)      pick = B_Req ? 2 : (A_Req ? 1 : 0);
    else if (m_owner == 2) pick = A_Req ? 1 : (B_Req ? 2 : 0);
    else if (A_Req && B_Req) pick = m_last_a ? 2 : 1;
    else                   pick = A_Req ? 1 : (B_Req ? 2 : 0);
    if (pick == 0) begin
      m_owner = 0;
      return;
    end
    d = (pick == 1) ? A_Data : B_Data;
    m_owner = pick;
    m_left = Hold - 1;
    m_last_a = (pick == 1);
    m_ack_a = (pick == 1);
    m_ack_b = (pick == 2);
    m_ten = (Blank_Zero && d[7:4] == 4'd0) ? 8'hFF : seg_tab[d[7:4]];
    m_one = seg_tab[d[3:0]];
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".owner"}, {6'd0, Owner}, 8'(m_owner));
    chk({tag, ".ten"}, Ten_SMG_Data, m_ten);
    chk({tag, ".one"}, One_SMG_Data, m_one);
    chk({tag, ".a_ack"}, {7'd0, A_Ack}, {7'd0, m_ack_a});
    chk({tag, ".b_ack"}, {7'd0, B_Ack}, {7'd0, m_ack_b});
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    A_Req = 0; B_Req = 0; Blank_Zero = 0;
    RSTn = 0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge CLK);
    #1;
    check_all("rst_hold");
    RSTn = 1;
  endtask

  // Reset pulse between edges, checked before the next edge.
  task automatic pulse_reset();
    RSTn = 0;
    #1;
    model_reset();
    check_all("rst_pulse");
    #1;
    RSTn = 1;
  endtask

  initial begin
    #2;
    do_reset();

    // Single request from idle.
    A_Req = 1; A_Data = 8'h42; Blank_Zero = 0;
    step("v030");
    chk("v030.ten", Ten_SMG_Data, 8'h99);
    chk("v030.one", One_SMG_Data, 8'hA4);
    chk("v030.ack", {7'd0, A_Ack}, 8'd1);
    A_Req = 0;
    for (int i = 0; i < 5; i++) step("v032");
    chk("v032.owner_idle", {6'd0, Owner}, 8'd0);
    chk("v032.keep", Ten_SMG_Data, 8'h99);

    // Tie from idle: A first, then alternation every Hold cycles with blanking.
    do_reset();
    A_Req = 1; B_Req = 1; A_Data = 8'h05; B_Data = 8'h17; Blank_Zero = 1;
    step("v031a");
    chk("v031.a_ten", Ten_SMG_Data, 8'hFF);
    chk("v031.a_one", One_SMG_Data, 8'h92);
    for (int i = 0; i < Hold; i++) step("v031b");
    chk("v031.b_owner", {6'd0, Owner}, 8'd2);
    chk("v031.b_ten", Ten_SMG_Data, 8'hF9);
    chk("v031.b_one", One_SMG_Data, 8'hF8);
    for (int i = 0; i < Hold; i++) step("v031c");
    chk("v031.a_again", {6'd0, Owner}, 8'd1);

    // Data change mid-hold is ignored until the reload edge.
    do_reset();
    A_Req = 1; A_Data = 8'h31;
    step("v033a");
    step("v033b");
    A_Data = 8'h99;
    step("v033c");
    step("v033d");
    chk("v033.frozen", Ten_SMG_Data, 8'hB0);
    step("v033e");
    chk("v033.ten", Ten_SMG_Data, 8'h90);
    chk("v033.one", One_SMG_Data, 8'h90);
    chk("v033.ack", {7'd0, A_Ack}, 8'd1);

    // Out-of-range BCD and a reset pulse mid-hold.
    do_reset();
    B_Req = 1; B_Data = 8'hA3;
    step("v034a");
    chk("v034.ten", Ten_SMG_Data, 8'hBF);
    chk("v034.one", One_SMG_Data, 8'hB0);
    step("v034b");
    pulse_reset();
    chk("v034.rst_ten", Ten_SMG_Data, 8'hFF);
    chk("v034.rst_owner", {6'd0, Owner}, 8'd0);
    step("v034c");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      A_Req = ($urandom_range(0, 2) != 0);
      B_Req = ($urandom_range(0, 2) == 0);
      A_Data = 8'($urandom);
      B_Data = 8'($urandom);
      Blank_Zero = 1'($urandom);
      if ($urandom_range(0, 3) == 0) A_Data[7:4] = 4'd0;
      if ($urandom_range(0, 60) == 0) pulse_reset();
      step("rnd");
      chk("rnd.ack_excl", {7'd0, A_Ack & B_Ack}, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
